benchmark_monitor: RTL and testbench

- Synthesizable self-checking monitor attached beside pipelined_processor.
- Snoops the writeback port and keeps a shadow register file, plus cycle and retired-write counters.
- On program end or watchdog timeout, sweeps a loadable expected-value table against the shadow file and reports PASS/FAIL, including the first mismatch.
- Generalises the fixed per-case register checks into a parametrised hardware checker, usable by simulation benches and FPGA bring-up.

---
 rtl/benchmark_pkg.sv | 24 ++
 rtl/shadow_regfile.sv | 40 ++++
 rtl/benchmark_monitor.sv | 187 ++++++++++++++++++
 tb/tb_benchmark_monitor.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/benchmark_pkg.sv
// Shared types and defaults for the benchmark monitor.
// State encoding, register-file defaults, expected-entry layout.
package benchmark_pkg;

  localparam int XLEN_DEF     = 64;
  localparam int NUM_REGS_DEF = 32;
  localparam int REG_W_DEF    = $clog2(NUM_REGS_DEF);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RUN   = 3'd1,
    ST_CHECK = 3'd2,
    ST_PASS  = 3'd3,
    ST_FAIL  = 3'd4
  } state_e;

  // One expected-table entry: {valid, reg, val}.
  typedef struct packed {
    logic                 valid;
    logic [REG_W_DEF-1:0] rg;
    logic [XLEN_DEF-1:0]  val;
  } exp_entry_t;

endpackage

// File: rtl/shadow_regfile.sv
// Shadow copy of the architectural register file.
// One write port, one combinational read port, x0 reads as zero.
module shadow_regfile
  import benchmark_pkg::*;
#(
  parameter  int XLEN     = XLEN_DEF,
  parameter  int NUM_REGS = NUM_REGS_DEF,
  localparam int RW       = $clog2(NUM_REGS)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            clr,
  input  logic            we,
  input  logic [RW-1:0]   waddr,
  input  logic [XLEN-1:0] wdata,
  input  logic [RW-1:0]   raddr,
  output logic [XLEN-1:0] rdata
);

  logic [NUM_REGS-1:0][XLEN-1:0] mem_q, mem_d;

  // Next contents: bulk clear wins, x0 writes are dropped.
  always_comb begin
    mem_d = mem_q;
    if (clr) begin
      mem_d = '0;
    end else if (we && waddr != '0) begin
      mem_d[waddr] = wdata;
    end
  end

  // Storage with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) mem_q <= '0;
    else        mem_q <= mem_d;
  end

  assign rdata = (raddr == '0) ? '0 : mem_q[raddr];

endmodule

// File: rtl/benchmark_monitor.sv
// Writeback snooper with shadow regfile, counters and watchdog.
// Sweeps an expected table on program end and reports pass/fail.
module benchmark_monitor
  import benchmark_pkg::*;
#(
  parameter  int XLEN           = XLEN_DEF,
  parameter  int NUM_REGS       = NUM_REGS_DEF,
  parameter  int NUM_CHECKS     = 16,
  parameter  int TIMEOUT_CYCLES = 1024,
  parameter  int CNT_W          = 32,
  localparam int RW             = $clog2(NUM_REGS),
  localparam int CW             = $clog2(NUM_CHECKS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             prog_done,
  input  logic             wb_en,
  input  logic [RW-1:0]    wb_rd,
  input  logic [XLEN-1:0]  wb_data,
  input  logic             exp_we,
  input  logic [CW-1:0]    exp_idx,
  input  logic             exp_valid,
  input  logic [RW-1:0]    exp_reg,
  input  logic [XLEN-1:0]  exp_val,
  output logic             busy,
  output logic             pass,
  output logic             fail,
  output logic             timed_out,
  output logic [CW-1:0]    fail_idx,
  output logic [XLEN-1:0]  fail_got,
  output logic [CNT_W-1:0] cycle_count,
  output logic [CNT_W-1:0] retire_count
);

  state_e                          state_q, state_d;
  logic [CW-1:0]                   ptr_q, ptr_d;
  logic [CNT_W-1:0]                cyc_q, cyc_d;
  logic [CNT_W-1:0]                ret_q, ret_d;
  logic                            busy_q, busy_d;
  logic                            pass_q, pass_d;
  logic                            fail_q, fail_d;
  logic                            to_q, to_d;
  logic [CW-1:0]                   fidx_q, fidx_d;
  logic [XLEN-1:0]                 fgot_q, fgot_d;
  logic [NUM_CHECKS-1:0]           ev_q, ev_d;
  logic [NUM_CHECKS-1:0][RW-1:0]   er_q, er_d;
  logic [NUM_CHECKS-1:0][XLEN-1:0] ex_q, ex_d;

  logic            sh_clr, sh_we;
  logic [XLEN-1:0] sh_rdata;
  logic            mismatch;

  shadow_regfile #(
    .XLEN     (XLEN),
    .NUM_REGS (NUM_REGS)
  ) u_shadow (
    .clk   (clk),
    .reset (reset),
    .clr   (sh_clr),
    .we    (sh_we),
    .waddr (wb_rd),
    .wdata (wb_data),
    .raddr (er_q[ptr_q]),
    .rdata (sh_rdata)
  );

  assign mismatch = ev_q[ptr_q] && (sh_rdata != ex_q[ptr_q]);

  // Next-state, counters, verdict and table-write logic.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cyc_d   = cyc_q;
    ret_d   = ret_q;
    pass_d  = pass_q;
    fail_d  = fail_q;
    to_d    = to_q;
    fidx_d  = fidx_q;
    fgot_d  = fgot_q;
    ev_d    = ev_q;
    er_d    = er_q;
    ex_d    = ex_q;
    sh_clr  = 1'b0;
    sh_we   = 1'b0;

    unique case (state_q)
      ST_IDLE, ST_PASS, ST_FAIL: begin
        if (exp_we) begin
          ev_d[exp_idx] = exp_valid;
          er_d[exp_idx] = exp_reg;
          ex_d[exp_idx] = exp_val;
        end
        if (start) begin
          state_d = ST_RUN;
          sh_clr  = 1'b1;
          cyc_d   = '0;
          ret_d   = '0;
          pass_d  = 1'b0;
          fail_d  = 1'b0;
          to_d    = 1'b0;
          fidx_d  = '0;
          fgot_d  = '0;
        end
      end
      ST_RUN: begin
        if (cyc_q != '1) cyc_d = cyc_q + CNT_W'(1);
        if (wb_en && wb_rd != '0) begin
          sh_we = 1'b1;
          if (ret_q != '1) ret_d = ret_q + CNT_W'(1);
        end
        if (prog_done) begin
          state_d = ST_CHECK;
          ptr_d   = '0;
        end else if (cyc_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          state_d = ST_CHECK;
          ptr_d   = '0;
          to_d    = 1'b1;
        end
      end
      ST_CHECK: begin
        if (mismatch) begin
          state_d = ST_FAIL;
          fail_d  = 1'b1;
          fidx_d  = ptr_q;
          fgot_d  = sh_rdata;
        end else if (ptr_q == CW'(NUM_CHECKS - 1)) begin
          if (to_q) begin
            state_d = ST_FAIL;
            fail_d  = 1'b1;
          end else begin
            state_d = ST_PASS;
            pass_d  = 1'b1;
          end
        end else begin
          ptr_d = ptr_q + CW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d == ST_RUN) || (state_d == ST_CHECK);
  end

  // State and datapath registers, synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      cyc_q   <= '0;
      ret_q   <= '0;
      busy_q  <= 1'b0;
      pass_q  <= 1'b0;
      fail_q  <= 1'b0;
      to_q    <= 1'b0;
      fidx_q  <= '0;
      fgot_q  <= '0;
      ev_q    <= '0;
      er_q    <= '0;
      ex_q    <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cyc_q   <= cyc_d;
      ret_q   <= ret_d;
      busy_q  <= busy_d;
      pass_q  <= pass_d;
      fail_q  <= fail_d;
      to_q    <= to_d;
      fidx_q  <= fidx_d;
      fgot_q  <= fgot_d;
      ev_q    <= ev_d;
      er_q    <= er_d;
      ex_q    <= ex_d;
    end
  end

  assign busy         = busy_q;
  assign pass         = pass_q;
  assign fail         = fail_q;
  assign timed_out    = to_q;
  assign fail_idx     = fidx_q;
  assign fail_got     = fgot_q;
  assign cycle_count  = cyc_q;
  assign retire_count = ret_q;

endmodule

// File: tb/tb_benchmark_monitor.sv
// Bench for benchmark_monitor: directed and random runs
// predicted by a sequential model of the monitor's rules.
module tb_benchmark_monitor;

  localparam int NC = 16;
  localparam int TO = 64;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        prog_done = 1'b0;
  logic        wb_en = 1'b0;
  logic [4:0]  wb_rd = '0;
  logic [63:0] wb_data = '0;
  logic        exp_we = 1'b0;
  logic [3:0]  exp_idx = '0;
  logic        exp_valid = 1'b0;
  logic [4:0]  exp_reg = '0;
  logic [63:0] exp_val = '0;
  logic        busy, pass, fail, timed_out;
  logic [3:0]  fail_idx;
  logic [63:0] fail_got;
  logic [31:0] cycle_count, retire_count;

  benchmark_monitor #(
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .prog_done    (prog_done),
    .wb_en        (wb_en),
    .wb_rd        (wb_rd),
    .wb_data      (wb_data),
    .exp_we       (exp_we),
    .exp_idx      (exp_idx),
    .exp_valid    (exp_valid),
    .exp_reg      (exp_reg),
    .exp_val      (exp_val),
    .busy         (busy),
    .pass         (pass),
    .fail         (fail),
    .timed_out    (timed_out),
    .fail_idx     (fail_idx),
    .fail_got     (fail_got),
    .cycle_count  (cycle_count),
    .retire_count (retire_count)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;

  // reference table and program
  bit          tab_v[NC];
  logic [4:0]  tab_r[NC];
  logic [63:0] tab_x[NC];
  bit          w_en[TO];
  logic [4:0]  w_rd[TO];
  logic [63:0] w_dat[TO];
  bit          run_poke = 1'b0;

  // predicted outcome
  logic [63:0] m_sh[32];
  int          e_cyc, e_ret, e_lat, e_idx;
  bit          e_pass, e_to;
  logic [63:0] e_got;

  task automatic chk(input string tag,
                     input logic [159:0] got,
                     input logic [159:0] exp);
    n_chk++;
    if (got !== exp)
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    else
      n_pass++;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".busy"}, 160'(busy), 160'(0));
    chk({tag, ".flags"}, 160'({pass, fail, timed_out}), 160'(0));
    chk({tag, ".fidx"}, 160'(fail_idx), 160'(0));
    chk({tag, ".fgot"}, 160'(fail_got), 160'(0));
    chk({tag, ".cnts"}, 160'({cycle_count, retire_count}), 160'(0));
  endtask

  task automatic clear_prog();
    for (int c = 0; c < TO; c++) begin
      w_en[c] = 1'b0;
      w_rd[c] = '0;
      w_dat[c] = '0;
    end
  endtask

  task automatic clear_tab();
    for (int i = 0; i < NC; i++) begin
      tab_v[i] = 1'b0;
      tab_r[i] = '0;
      tab_x[i] = '0;
    end
  endtask

  task automatic load_table();
    for (int i = 0; i < NC; i++) begin
      @(negedge clk);
      exp_we = 1'b1;
      exp_idx = 4'(i);
      exp_valid = tab_v[i];
      exp_reg = tab_r[i];
      exp_val = tab_x[i];
    end
    @(negedge clk);
    exp_we = 1'b0;
  endtask

  // Outcome of a run of L cycles, ended by done or the watchdog.
  task automatic predict(input int L, input bit done);
    for (int r = 0; r < 32; r++) m_sh[r] = '0;
    e_ret = 0;
    for (int c = 0; c < L; c++)
      if (w_en[c] && w_rd[c] != 0) begin
        m_sh[w_rd[c]] = w_dat[c];
        e_ret++;
      end
    e_cyc = L;
    e_to = !done;
    e_idx = -1;
    for (int i = 0; i < NC && e_idx < 0; i++)
      if (tab_v[i] && m_sh[tab_r[i]] !== tab_x[i]) e_idx = i;
    if (e_idx >= 0) begin
      e_lat = e_idx + 1;
      e_pass = 1'b0;
      e_got = m_sh[tab_r[e_idx]];
    end else begin
      e_lat = NC;
      e_pass = !e_to;
      e_idx = 0;
      e_got = '0;
    end
  endtask

  task automatic run_body(input string tag, input int L, input bit done);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk({tag, ".busy_run"}, 160'(busy), 160'(1));
    for (int c = 0; c < L; c++) begin
      wb_en = w_en[c];
      wb_rd = w_rd[c];
      wb_data = w_dat[c];
      prog_done = done && (c == L - 1);
      if (run_poke && c == 0) begin
        exp_we = 1'b1;
        exp_idx = 4'd5;
        exp_valid = 1'b1;
        exp_reg = 5'd7;
        exp_val = 64'd123;
      end
      @(negedge clk);
      wb_en = 1'b0;
      prog_done = 1'b0;
      exp_we = 1'b0;
    end
  endtask

  task automatic run_end(input string tag);
    int lat;
    lat = 0;
    while (busy && lat < 40) begin
      lat++;
      @(negedge clk);
    end
    chk({tag, ".latency"}, 160'(lat), 160'(e_lat));
    chk({tag, ".pass"}, 160'(pass), 160'(e_pass));
    chk({tag, ".fail"}, 160'(fail), 160'(!e_pass));
    chk({tag, ".timed_out"}, 160'(timed_out), 160'(e_to));
    chk({tag, ".fail_idx"}, 160'(fail_idx), 160'(e_idx));
    chk({tag, ".fail_got"}, 160'(fail_got), 160'(e_got));
    chk({tag, ".cycles"}, 160'(cycle_count), 160'(e_cyc));
    chk({tag, ".retired"}, 160'(retire_count), 160'(e_ret));
  endtask

  task automatic run_case(input string tag, input int L, input bit done);
    predict(L, done);
    run_body(tag, L, done);
    run_end(tag);
  endtask

  task automatic wr(input int c, input int rd, input logic [63:0] d);
    w_en[c] = 1'b1;
    w_rd[c] = 5'(rd);
    w_dat[c] = d;
  endtask

  task automatic basic_table();
    clear_tab();
    tab_v[0] = 1; tab_r[0] = 5'd1; tab_x[0] = 64'd16;
    tab_v[1] = 1; tab_r[1] = 5'd2; tab_x[1] = 64'd8;
    tab_v[2] = 1; tab_r[2] = 5'd3; tab_x[2] = 64'd24;
    tab_v[3] = 1; tab_r[3] = 5'd4; tab_x[3] = 64'd10;
  endtask

  initial begin
    clear_prog();
    clear_tab();
    repeat (2) @(negedge clk);
    reset = 1'b1;
    chk_zero("reset");

    // pass path
    basic_table();
    load_table();
    clear_prog();
    wr(0, 1, 16); wr(1, 2, 8); wr(2, 4, 10); wr(3, 3, 24);
    run_case("pass", 12, 1'b1);

    // mismatch on entry 2, sweep aborts there
    tab_v[5] = 1; tab_r[5] = 5'd9; tab_x[5] = 64'd77;
    load_table();
    w_dat[3] = 64'd23;
    run_case("mism", 12, 1'b1);
    chk("mism.ptr", 160'(dut.ptr_q), 160'(2));

    // negative value and x0
    clear_tab();
    tab_v[0] = 1; tab_r[0] = 5'd2; tab_x[0] = 64'hFFFF_FFFF_FFFF_FFF6;
    tab_v[1] = 1; tab_r[1] = 5'd0; tab_x[1] = 64'd0;
    load_table();
    clear_prog();
    wr(1, 2, -64'sd10); wr(2, 0, 64'd5);
    run_case("neg", 6, 1'b1);

    // watchdog with all entries matching
    basic_table();
    load_table();
    clear_prog();
    wr(0, 1, 16); wr(1, 2, 8); wr(2, 4, 10); wr(3, 3, 24);
    run_case("wdog", TO, 1'b0);

    // done coincides with the watchdog
    run_case("both", TO, 1'b1);

    // randomised runs
    for (int t = 0; t < 8; t++) begin
      bit dn;
      int L;
      for (int i = 0; i < NC; i++) begin
        tab_v[i] = ($urandom_range(0, 3) == 0);
        tab_r[i] = 5'($urandom_range(0, 7));
        tab_x[i] = 64'($urandom_range(0, 1));
      end
      load_table();
      dn = ($urandom_range(0, 3) != 0);
      L = dn ? int'($urandom_range(1, TO)) : TO;
      for (int c = 0; c < TO; c++) begin
        w_en[c] = ($urandom_range(0, 1) == 1);
        w_rd[c] = 5'($urandom_range(0, 7));
        w_dat[c] = 64'($urandom_range(0, 1));
      end
      run_case($sformatf("rnd%0d", t), L, dn);
    end

    // reset in the middle of a long sweep
    clear_tab();
    for (int i = 0; i < NC; i++) tab_v[i] = 1;
    load_table();
    clear_prog();
    run_body("rst", 5, 1'b1);
    repeat (3) @(negedge clk);
    chk("rst.in_check", 160'(busy), 160'(1));
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    chk_zero("rst");

    // empty table after reset; table writes in RUN ignored
    clear_tab();
    run_poke = 1'b1;
    run_case("empty", 8, 1'b1);
    run_poke = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1);
  end

endmodule
